// File: rtl/ssd_frame_decoder_if.sv
// ssd_frame_decoder_if
//   Bundles the multiplexed seven-segment bus being monitored together with
//   the decoded frame results.
//   master : the side driving the display bus (en, seg_in, dig_sel) and
//            consuming the decoded frame.
//   slave  : the frame decoder itself.
//   Signals:
//     en          capture enable
//     seg_in      {a,b,c,d,e,f,g}, a is MSB, 1 = lit
//     dig_sel     one-hot digit select, bit 0 = least significant digit
//     value       last complete frame, digit i in [4i+3:4i]
//     blank_mask  digit i of last frame was blank
//     err_mask    digit i of last frame was an illegal pattern
//     frame_valid one-cycle pulse when the frame outputs update
//     sel_err     sticky: an accepted dig_sel was not one-hot
//     busy        a frame is partially captured
interface ssd_frame_decoder_if #(
  parameter int N_DIG = 4
);
  logic                 en;
  logic [6:0]           seg_in;
  logic [N_DIG-1:0]     dig_sel;
  logic [4*N_DIG-1:0]   value;
  logic [N_DIG-1:0]     blank_mask;
  logic [N_DIG-1:0]     err_mask;
  logic                 frame_valid;
  logic                 sel_err;
  logic                 busy;

  modport master (
    output en, seg_in, dig_sel,
    input  value, blank_mask, err_mask, frame_valid, sel_err, busy
  );

  modport slave (
    input  en, seg_in, dig_sel,
    output value, blank_mask, err_mask, frame_valid, sel_err, busy
  );
endinterface

// File: rtl/ssd_frame_decoder.sv
// ssd_frame_decoder
//   Monitors a multiplexed seven-segment bus, filters scan transients with a
//   stability counter, decodes each accepted pattern back to a hex nibble and
//   assembles a multi-digit frame.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    ssd_frame_decoder_if.slave (bus inputs + frame outputs)
//   Parameters:
//     N_DIG       number of multiplexed digits
//     STABLE_CYC  identical consecutive samples needed to accept (1..15)
module ssd_frame_decoder #(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 3
) (
  input logic              clk,
  input logic              rst_n,
  ssd_frame_decoder_if.slave bus
);

  localparam int CW = 4;

  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       err;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] p);
    dec_t r;
    r = '{nib: 4'h0, blank: 1'b0, err: 1'b0};
    case (p)
      7'b1111110: r.nib = 4'h0;
      7'b0110000: r.nib = 4'h1;
      7'b1101101: r.nib = 4'h2;
      7'b1111001: r.nib = 4'h3;
      7'b0110011: r.nib = 4'h4;
      7'b1011011: r.nib = 4'h5;
      7'b1011111: r.nib = 4'h6;
      7'b1110000: r.nib = 4'h7;
      7'b1111111: r.nib = 4'h8;
      7'b1111011: r.nib = 4'h9;
      7'b1110111: r.nib = 4'hA;
      7'b0011111: r.nib = 4'hB;
      7'b1001110: r.nib = 4'hC;
      7'b0111101: r.nib = 4'hD;
      7'b1001111: r.nib = 4'hE;
      7'b1000111: r.nib = 4'hF;
      7'b0000000: r.blank = 1'b1;
      default:    r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Sample stage and stability filter
  logic [6:0]       seg_q;
  logic [N_DIG-1:0] sel_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             same;

  assign same = (bus.seg_in == seg_q) && (bus.dig_sel == sel_q);

  always_comb begin
    cnt_d = cnt_q;
    acc_d = 1'b0;
    if (!bus.en) begin
      cnt_d = '0;
    end else begin
      if (!same)
        cnt_d = CW'(1);
      else if (cnt_q < CW'(STABLE_CYC))
        cnt_d = cnt_q + CW'(1);
      // Fire only on arrival at the threshold; a held value sitting at the
      // threshold is not re-accepted until the input changes.
      acc_d = (cnt_d == CW'(STABLE_CYC)) &&
              !(same && (cnt_q == CW'(STABLE_CYC)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      seg_q <= bus.seg_in;
      sel_q <= bus.dig_sel;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  // Accepted sample is still in seg_q/sel_q on the edge after the strobe.
  dec_t dec;
  logic sel_ok, wr, bad_sel;

  assign dec     = decode(seg_q);
  assign sel_ok  = $onehot(sel_q);
  assign wr      = acc_q && bus.en && sel_ok;
  assign bad_sel = acc_q && bus.en && !sel_ok;

  // Shadow frame, one lane per digit
  logic [N_DIG-1:0][3:0] nib_q;
  logic [N_DIG-1:0]      blank_sh_q, err_sh_q;

  for (genvar i = 0; i < N_DIG; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        nib_q[i]      <= 4'h0;
        blank_sh_q[i] <= 1'b0;
        err_sh_q[i]   <= 1'b0;
      end else if (wr && sel_q[i]) begin
        nib_q[i]      <= dec.nib;
        blank_sh_q[i] <= dec.blank;
        err_sh_q[i]   <= dec.err;
      end
    end
  end

  // Frame tracking
  logic [N_DIG-1:0] seen_q, seen_d;
  logic             done;

  assign done = bus.en && (&seen_q);

  always_comb begin
    seen_d = seen_q;
    if (!bus.en) begin
      seen_d = '0;
    end else begin
      if (done) seen_d = '0;
      // A write on the completion edge seeds the next frame.
      if (wr) seen_d = seen_d | sel_q;
    end
  end

  logic [4*N_DIG-1:0] value_q;
  logic [N_DIG-1:0]   blank_q, err_q;
  logic               fv_q, sel_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q    <= '0;
      value_q   <= '0;
      blank_q   <= '0;
      err_q     <= '0;
      fv_q      <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      seen_q    <= seen_d;
      fv_q      <= done;
      sel_err_q <= sel_err_q | bad_sel;
      if (done) begin
        value_q <= nib_q;
        blank_q <= blank_sh_q;
        err_q   <= err_sh_q;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.blank_mask  = blank_q;
  assign bus.err_mask    = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.busy        = |seen_q;

endmodule

// File: tb/tb_ssd_frame_decoder.sv
module tb_ssd_frame_decoder;

  localparam int N_DIG = 4;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                         P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                         P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                         P9 = 7'b1111011, PA = 7'b1110111, PB = 7'b0011111,
                         PC = 7'b1001110, PD = 7'b0111101, PE = 7'b1001111,
                         PF = 7'b1000111, PBLK = 7'b0000000, PBAD = 7'b1010101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   fv_cnt = 0;
  int   fv_base;

  ssd_frame_decoder_if #(.N_DIG(N_DIG)) bus ();

  ssd_frame_decoder #(.N_DIG(N_DIG), .STABLE_CYC(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counts frame_valid pulses; sampled pre-update at each rising edge.
  always @(posedge clk) if (bus.frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Presents a pattern for n rising edges; entered and left at a falling edge.
  task automatic drive(input logic [6:0] seg, input logic [N_DIG-1:0] sel, input int n);
    bus.en      = 1'b1;
    bus.seg_in  = seg;
    bus.dig_sel = sel;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    drive(p0, 4'b0001, 4);
    drive(p1, 4'b0010, 4);
    drive(p2, 4'b0100, 4);
    drive(p3, 4'b1000, 4);
  endtask

  // Called right after the last digit's 4-cycle hold: frame lands one edge later.
  task automatic expect_frame(input string tag, input logic [15:0] v,
                              input logic [3:0] b, input logic [3:0] e);
    chk({tag, "_fv_early"}, 32'(bus.frame_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_fv"},    32'(bus.frame_valid), 32'd1);
    chk({tag, "_value"}, 32'(bus.value),       32'(v));
    chk({tag, "_blank"}, 32'(bus.blank_mask),  32'(b));
    chk({tag, "_err"},   32'(bus.err_mask),    32'(e));
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.seg_in  = 7'd0;
    bus.dig_sel = 4'd0;

    // Reset state
    @(negedge clk);
    chk("rst_value",   32'(bus.value),       32'd0);
    chk("rst_blank",   32'(bus.blank_mask),  32'd0);
    chk("rst_err",     32'(bus.err_mask),    32'd0);
    chk("rst_fv",      32'(bus.frame_valid), 32'd0);
    chk("rst_selerr",  32'(bus.sel_err),     32'd0);
    chk("rst_busy",    32'(bus.busy),        32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame 3,0,F,A
    fv_base = fv_cnt;
    scan4(P3, P0, PF, PA);
    chk("f1_busy", 32'(bus.busy), 32'd1);
    expect_frame("f1", 16'hAF03, 4'b0000, 4'b0000);
    @(negedge clk);
    chk("f1_fv_drop", 32'(bus.frame_valid), 32'd0);
    chk("f1_busy_clr", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("f1_once", 32'(fv_cnt - fv_base), 32'd1);

    // Glitch filter: 5 for 2 cycles, then 1 for 3 cycles
    drive(P5, 4'b0001, 2);
    drive(P1, 4'b0001, 3);
    drive(P2, 4'b0010, 4);
    drive(P3, 4'b0100, 4);
    drive(P4, 4'b1000, 4);
    expect_frame("glitch", 16'h4321, 4'b0000, 4'b0000);

    // Blank and illegal digits
    scan4(P1, PBLK, PBAD, P8);
    expect_frame("blkerr", 16'h8001, 4'b0010, 4'b0100);

    // Multi-hot select mid-frame
    drive(P5, 4'b0001, 4);
    chk("sel_busy_pre", 32'(bus.busy), 32'd1);
    drive(P0, 4'b0110, 5);
    chk("sel_err_set", 32'(bus.sel_err), 32'd1);
    chk("sel_busy_post", 32'(bus.busy), 32'd1);
    drive(P6, 4'b0010, 4);
    drive(P7, 4'b0100, 4);
    drive(P9, 4'b1000, 4);
    expect_frame("selfrm", 16'h9765, 4'b0000, 4'b0000);
    chk("sel_err_sticky", 32'(bus.sel_err), 32'd1);

    // Recapture digit 2: 7 then 9
    drive(P0, 4'b0001, 4);
    drive(P1, 4'b0010, 4);
    drive(P7, 4'b0100, 4);
    drive(P9, 4'b0100, 4);
    drive(PC, 4'b1000, 4);
    expect_frame("recap", 16'hC910, 4'b0000, 4'b0000);

    // Enable low clears seen; re-enable needs 3 fresh samples
    drive(P1, 4'b0001, 4);
    chk("en_busy_pre", 32'(bus.busy), 32'd1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("en_busy_clr", 32'(bus.busy), 32'd0);
    chk("en_value_hold", 32'(bus.value), 32'h0000C910);
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_busy_wait", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("en_busy_acc", 32'(bus.busy), 32'd1);

    // Asynchronous reset mid-frame
    drive(P3, 4'b0010, 4);
    #2;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    #1;
    chk("arst_value",  32'(bus.value),       32'd0);
    chk("arst_blank",  32'(bus.blank_mask),  32'd0);
    chk("arst_err",    32'(bus.err_mask),    32'd0);
    chk("arst_fv",     32'(bus.frame_valid), 32'd0);
    chk("arst_selerr", 32'(bus.sel_err),     32'd0);
    chk("arst_busy",   32'(bus.busy),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fv_base = fv_cnt;
    scan4(PA, PB, PC, PD);
    chk("post_rst_nofv", 32'(fv_cnt - fv_base), 32'd0);
    expect_frame("postrst", 16'hDCBA, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    chk("post_rst_once", 32'(fv_cnt - fv_base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
